// File: rtl/sm_config_pkg.sv
// -----------------------------------------------------------------------------
// sm_config_pkg
//
// Shared configuration for the run-control block and the CPU debug logic.
//
// Contents:
//   run_state_e  - run-control state encoding (HALT=0, RUN=1, STEP=2, BREAK=3)
//   EXP_CLAMP    - largest allowed tick-period exponent (period = 2^E clocks)
//   tick_mask    - terminal-count mask for the prescaler, 2^E - 1 with
//                  E = min(shift + devide, EXP_CLAMP)
// -----------------------------------------------------------------------------
package sm_config_pkg;

  // The numeric values are visible to software through the state output,
  // so they are pinned explicitly rather than left to enum defaults.
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  // A 32-bit prescaler can count at most 2^31 cycles between ticks without
  // the mask overflowing, so the exponent is clamped here.
  localparam int unsigned EXP_CLAMP = 31;

  // Terminal value of the prescaler for the requested exponent.
  function automatic logic [31:0] tick_mask(input int unsigned shift,
                                            input logic [3:0]  devide);
    int unsigned e;
    e = shift + {28'd0, devide};
    if (e > EXP_CLAMP) begin
      e = EXP_CLAMP;
    end
    return (32'd1 << e) - 32'd1;
  endfunction

endpackage : sm_config_pkg

// File: rtl/sm_edge_detect.sv
// -----------------------------------------------------------------------------
// sm_edge_detect
//
// Rising-edge detector for one already-debounced button level.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active-low
//   sig    in   button level
//   rise   out  one-clock pulse, registered, in the cycle after the sampled
//               0->1 change of sig
//
// The history register is loaded from the input on the first clock after
// reset release without producing a pulse, so a button that is held through
// reset has to be released and pressed again before it counts.
// -----------------------------------------------------------------------------
module sm_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev;
  logic armed;

  // armed stays low for exactly one clock after reset; during that clock the
  // history is captured but no edge may be reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      rise  <= 1'b0;
    end else begin
      prev  <= sig;
      armed <= 1'b1;
      rise  <= armed & sig & ~prev;
    end
  end

endmodule : sm_edge_detect

// File: rtl/sm_run_ctrl.sv
// -----------------------------------------------------------------------------
// sm_run_ctrl
//
// Run / halt / single-step / breakpoint controller for the soft CPU. Produces
// a one-clock CPU clock-enable pulse every 2^E system clocks while running or
// stepping, where E = min(SHIFT + devide, 31).
//
// Parameters:
//   SHIFT     base exponent of the CPU tick period
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active-low
//   devide    in   period exponent offset
//   btnRun    in   run request (debounced level)
//   btnHalt   in   halt request (debounced level)
//   btnStep   in   step request (debounced level)
//   stepN     in   CPU ticks per step press (0 behaves as 1)
//   bpEnable  in   breakpoint enable
//   bpAddr    in   breakpoint instruction address
//   pc        in   current CPU instruction address
//   cpuTick   out  CPU clock-enable pulse (registered)
//   state     out  HALT=0, RUN=1, STEP=2, BREAK=3 (registered)
//   cycleCnt  out  number of issued cpuTick pulses, saturating
//   bpHit     out  high while state is BREAK
// -----------------------------------------------------------------------------
module sm_run_ctrl #(
  parameter int unsigned SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  devide,
  input  logic        btnRun,
  input  logic        btnHalt,
  input  logic        btnStep,
  input  logic [7:0]  stepN,
  input  logic        bpEnable,
  input  logic [31:0] bpAddr,
  input  logic [31:0] pc,
  output logic        cpuTick,
  output logic [1:0]  state,
  output logic [31:0] cycleCnt,
  output logic        bpHit
);

  import sm_config_pkg::*;

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  logic run_rise;
  logic halt_rise;
  logic step_rise;

  sm_edge_detect u_run_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (btnRun),
    .rise  (run_rise)
  );

  sm_edge_detect u_halt_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (btnHalt),
    .rise  (halt_rise)
  );

  sm_edge_detect u_step_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (btnStep),
    .rise  (step_rise)
  );

  // Only the highest-priority edge of a cycle survives: halt > step > run.
  logic halt_ev;
  logic step_ev;
  logic run_ev;

  assign halt_ev = halt_rise;
  assign step_ev = step_rise & ~halt_rise;
  assign run_ev  = run_rise & ~halt_rise & ~step_rise;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  run_state_e  state_q;
  run_state_e  state_d;
  logic [7:0]  steps_q;
  logic [7:0]  steps_d;
  logic        skip_q;
  logic        skip_d;
  logic [31:0] presc;
  logic [31:0] presc_d;
  logic        presc_clr;
  logic        tick_d;
  logic        cpu_tick;
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_cnt_d;
  logic        bp_hit;

  logic [31:0] mask;
  logic        terminal;
  logic        bp_match;
  logic [7:0]  step_load;

  // The mask is evaluated combinationally from the live devide input, so a
  // change of devide is picked up by the very next compare.
  assign mask      = tick_mask(SHIFT, devide);
  assign terminal  = (presc >= mask);
  assign bp_match  = bpEnable && (pc == bpAddr);
  assign step_load = (stepN == 8'd0) ? 8'd1 : stepN;

  // ---------------------------------------------------------------------------
  // Next-state, tick and bookkeeping logic
  // ---------------------------------------------------------------------------
  // A terminal cycle in RUN always issues a tick unless a breakpoint matches
  // and the one-shot skip flag is clear; a halt or step edge landing in the
  // same cycle changes the state but does not take that tick back. In STEP
  // a halt edge aborts the tick of its cycle. Every entry into RUN or STEP
  // restarts the prescaler so the first tick is a full period later.
  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    skip_d    = skip_q;
    tick_d    = 1'b0;
    presc_clr = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (step_ev) begin
          state_d   = ST_STEP;
          steps_d   = step_load;
          presc_clr = 1'b1;
        end else if (run_ev) begin
          state_d   = ST_RUN;
          presc_clr = 1'b1;
        end
      end

      ST_RUN: begin
        if (terminal) begin
          skip_d = 1'b0;
          if (skip_q || !bp_match) begin
            tick_d = 1'b1;
          end
        end
        if (halt_ev) begin
          state_d = ST_HALT;
        end else if (step_ev) begin
          state_d   = ST_STEP;
          steps_d   = step_load;
          presc_clr = 1'b1;
        end else if (terminal && !skip_q && bp_match) begin
          state_d = ST_BREAK;
        end
      end

      ST_STEP: begin
        if (halt_ev) begin
          state_d = ST_HALT;
          steps_d = 8'd0;
        end else if (terminal) begin
          tick_d  = 1'b1;
          steps_d = steps_q - 8'd1;
          if (steps_q <= 8'd1) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_BREAK: begin
        if (halt_ev) begin
          state_d = ST_HALT;
        end else if (step_ev) begin
          state_d   = ST_STEP;
          steps_d   = step_load;
          presc_clr = 1'b1;
        end else if (run_ev) begin
          state_d   = ST_RUN;
          skip_d    = 1'b1;
          presc_clr = 1'b1;
        end
      end
    endcase

    if (presc_clr || terminal) begin
      presc_d = 32'd0;
    end else begin
      presc_d = presc + 32'd1;
    end

    if (tick_d && (cycle_cnt != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt + 32'd1;
    end else begin
      cycle_cnt_d = cycle_cnt;
    end
  end

  // All outputs come straight from flops; bpHit follows the next state so it
  // lines up with the state output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      steps_q   <= 8'd0;
      skip_q    <= 1'b0;
      presc     <= 32'd0;
      cpu_tick  <= 1'b0;
      cycle_cnt <= 32'd0;
      bp_hit    <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      skip_q    <= skip_d;
      presc     <= presc_d;
      cpu_tick  <= tick_d;
      cycle_cnt <= cycle_cnt_d;
      bp_hit    <= (state_d == ST_BREAK);
    end
  end

  assign cpuTick  = cpu_tick;
  assign state    = state_q;
  assign cycleCnt = cycle_cnt;
  assign bpHit    = bp_hit;

endmodule : sm_run_ctrl

// File: tb/tb_sm_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm_run_ctrl
//
// Self-checking bench for sm_run_ctrl with SHIFT=0. Expected tick times are
// derived from the entry cycle and the period 2^devide; cycle counts come
// from a saturating sum of expected ticks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sm_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  devide = 4'd0;
  logic        btn_run = 1'b0;
  logic        btn_halt = 1'b0;
  logic        btn_step = 1'b0;
  logic [7:0]  step_n = 8'd1;
  logic        bp_enable = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        cpu_tick;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic        bp_hit;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          tick_q[$];
  logic [31:0] model_cnt = 32'd0;
  logic [31:0] pc_at [int];

  sm_run_ctrl #(.SHIFT(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .devide   (devide),
    .btnRun   (btn_run),
    .btnHalt  (btn_halt),
    .btnStep  (btn_step),
    .stepN    (step_n),
    .bpEnable (bp_enable),
    .bpAddr   (bp_addr),
    .pc       (pc),
    .cpuTick  (cpu_tick),
    .state    (state),
    .cycleCnt (cycle_cnt),
    .bpHit    (bp_hit)
  );

  // 10 ns clock; cyc counts rising edges.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge number of every tick, sampled on the falling edge.
  always @(negedge clk) begin
    if (cpu_tick === 1'b1) tick_q.push_back(cyc);
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
    longint s;
    s = longint'({32'd0, a}) + longint'(n);
    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Number of discrepancies between recorded ticks and n ticks at
  // first, first+period, ...
  function automatic int tick_errors(input int first, input int period, input int n);
    int errs;
    errs = 0;
    if (int'(tick_q.size()) != n) errs++;
    for (int k = 0; k < n && k < int'(tick_q.size()); k++) begin
      if (tick_q[k] != first + k * period) errs++;
    end
    return errs;
  endfunction

  // Pulse the selected buttons for one cycle. entry is the edge at which the
  // resulting state change takes effect (edge detect + state register).
  task automatic press(input bit r, input bit h, input bit s, output int entry);
    @(negedge clk);
    btn_run  = r;
    btn_halt = h;
    btn_step = s;
    entry = cyc + 2;
    @(negedge clk);
    btn_run  = 1'b0;
    btn_halt = 1'b0;
    btn_step = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    tests_run++;
    if (cpu_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick: got %0b expected 0", cpu_tick); end
    tests_run++;
    if (cycle_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0h expected 0", cycle_cnt); end
    tests_run++;
    if (bp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bphit: got %0b expected 0", bp_hit); end
    rst_n = 1'b1;
    model_cnt = 32'd0;
    tick_q.delete();
    repeat (5) @(negedge clk);
    tests_run++;
    if (tick_q.size() != 0 || state !== 2'd0) begin
      tests_failed++; $display("[TB] FAIL reset_idle: got ticks=%0d state=%0d expected 0/0", tick_q.size(), state);
    end
  endtask

  task automatic test_run();
    int entry, eh, p, k, errs;
    logic [31:0] base;
    devide = 4'd2; p = 4; base = model_cnt; tick_q.delete();
    press(1, 0, 0, entry);
    wait_to(entry);
    tests_run++;
    if (state !== 2'd1) begin tests_failed++; $display("[TB] FAIL run_entry: got %0d expected 1", state); end
    wait_to(entry + 10 * p + 2);
    errs = tick_errors(entry + p, p, 10);
    tests_run++;
    if (errs !== 0) begin tests_failed++; $display("[TB] FAIL run_ticks: got %0d errors (%0d ticks) expected 0 errors", errs, tick_q.size()); end
    model_cnt = sat_add(base, 10);
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL run_cnt: got %0d expected %0d", cycle_cnt, model_cnt); end
    press(0, 1, 0, eh);
    wait_to(eh + 3 * p);
    k = (eh - 1 - entry) / p;
    errs = tick_errors(entry + p, p, k);
    tests_run++;
    if (errs !== 0) begin tests_failed++; $display("[TB] FAIL halt_ticks: got %0d ticks expected %0d", tick_q.size(), k); end
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL halt_state: got %0d expected 0", state); end
    model_cnt = sat_add(base, k);
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL halt_cnt: got %0d expected %0d", cycle_cnt, model_cnt); end
  endtask

  task automatic test_step();
    int entry, p, n, sn, dv, errs;
    for (int i = 0; i < 6; i++) begin
      sn = (i == 0) ? 3 : (i == 1) ? 0 : int'($urandom_range(0, 6));
      dv = (i < 2) ? 2 : int'($urandom_range(0, 3));
      devide = dv[3:0]; step_n = sn[7:0];
      p = 1 << dv; n = (sn == 0) ? 1 : sn;
      tick_q.delete();
      press(0, 0, 1, entry);
      wait_to(entry);
      tests_run++;
      if (state !== 2'd2) begin tests_failed++; $display("[TB] FAIL step_entry: got %0d expected 2", state); end
      wait_to(entry + n * p + 3);
      errs = tick_errors(entry + p, p, n);
      tests_run++;
      if (errs !== 0) begin tests_failed++; $display("[TB] FAIL step_ticks: got %0d ticks expected %0d (stepN=%0d devide=%0d)", tick_q.size(), n, sn, dv); end
      tests_run++;
      if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL step_done: got %0d expected 0", state); end
      model_cnt = sat_add(model_cnt, n);
      tests_run++;
      if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL step_cnt: got %0d expected %0d", cycle_cnt, model_cnt); end
    end
  endtask

  task automatic test_breakpoint();
    int entry, e2, eh, p, dv, len, loop_end, brk, n, errs;
    logic [1:0] exp_state;
    // Directed: hit, resume with skip, hit again.
    devide = 4'd2; p = 4; bp_enable = 1'b1; bp_addr = 32'h20; pc = 32'h20;
    tick_q.delete();
    press(1, 0, 0, entry);
    wait_to(entry + p + 1);
    tests_run++;
    if (tick_q.size() != 0) begin tests_failed++; $display("[TB] FAIL bp_no_tick: got %0d ticks expected 0", tick_q.size()); end
    tests_run++;
    if (state !== 2'd3) begin tests_failed++; $display("[TB] FAIL bp_state: got %0d expected 3", state); end
    tests_run++;
    if (bp_hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_hit: got %0b expected 1", bp_hit); end
    press(1, 0, 0, e2);
    wait_to(e2 + p + 1);
    errs = tick_errors(e2 + p, p, 1);
    tests_run++;
    if (errs !== 0) begin tests_failed++; $display("[TB] FAIL bp_skip_tick: got %0d ticks expected 1", tick_q.size()); end
    tests_run++;
    if (state !== 2'd1 || bp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_resume: got state=%0d bphit=%0b expected 1/0", state, bp_hit); end
    wait_to(e2 + 2 * p + 1);
    errs = tick_errors(e2 + p, p, 1);
    tests_run++;
    if (errs !== 0 || state !== 2'd3) begin tests_failed++; $display("[TB] FAIL bp_rebreak: got ticks=%0d state=%0d expected 1/3", tick_q.size(), state); end
    model_cnt = sat_add(model_cnt, 1);
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL bp_cnt: got %0d expected %0d", cycle_cnt, model_cnt); end
    press(0, 1, 0, eh);
    wait_to(eh + 1);
    tests_run++;
    if (state !== 2'd0 || bp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_halt: got state=%0d bphit=%0b expected 0/0", state, bp_hit); end

    // Randomised: pc wanders, the first terminal with a matching pc breaks.
    for (int it = 0; it < 3; it++) begin
      dv = int'($urandom_range(1, 2)); devide = dv[3:0]; p = 1 << dv;
      bp_addr = $urandom; pc = bp_addr ^ 32'h4;
      pc_at.delete(); tick_q.delete();
      press(1, 0, 0, entry);
      len = 10 * p;
      for (int c = 0; c < len; c++) begin
        pc = ($urandom_range(0, 3) == 0) ? bp_addr : (bp_addr ^ ($urandom | 32'h1));
        pc_at[cyc + 1] = pc;
        @(negedge clk);
      end
      pc = bp_addr ^ 32'h4;
      loop_end = cyc;
      brk = -1;
      for (int e = entry + p; e <= loop_end; e += p) begin
        if (pc_at.exists(e) && pc_at[e] == bp_addr) begin brk = e; break; end
      end
      exp_state = (brk != -1) ? 2'd3 : 2'd1;
      tests_run++;
      if (state !== exp_state) begin tests_failed++; $display("[TB] FAIL bp_rand_state: got %0d expected %0d", state, exp_state); end
      @(negedge clk);
      press(0, 1, 0, eh);
      wait_to(eh + 2);
      n = (brk != -1) ? (brk - entry) / p - 1 : (eh - 1 - entry) / p;
      errs = tick_errors(entry + p, p, n);
      tests_run++;
      if (errs !== 0) begin tests_failed++; $display("[TB] FAIL bp_rand_ticks: got %0d ticks expected %0d", tick_q.size(), n); end
      model_cnt = sat_add(model_cnt, n);
      tests_run++;
      if (cycle_cnt !== model_cnt || state !== 2'd0) begin
        tests_failed++; $display("[TB] FAIL bp_rand_cnt: got cnt=%0d state=%0d expected %0d/0", cycle_cnt, state, model_cnt);
      end
    end
    bp_enable = 1'b0;
  endtask

  task automatic test_simultaneous();
    int entry, eh, e, p, k, errs;
    devide = 4'd1; p = 2; tick_q.delete();
    press(1, 0, 0, entry);
    wait_to(entry + 3 * p + 2);
    press(1, 1, 0, eh);
    wait_to(eh + 5 * p);
    k = (eh - 1 - entry) / p;
    errs = tick_errors(entry + p, p, k);
    tests_run++;
    if (errs !== 0) begin tests_failed++; $display("[TB] FAIL simul_ticks: got %0d ticks expected %0d", tick_q.size(), k); end
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL simul_state: got %0d expected 0", state); end
    model_cnt = sat_add(model_cnt, k);
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL simul_cnt: got %0d expected %0d", cycle_cnt, model_cnt); end

    // Halt outranks step even in HALT, so the step is discarded.
    step_n = 8'd2; tick_q.delete();
    press(0, 1, 1, e);
    wait_to(e + 4 * p);
    tests_run++;
    if (tick_q.size() != 0 || state !== 2'd0) begin
      tests_failed++; $display("[TB] FAIL halt_step_discard: got ticks=%0d state=%0d expected 0/0", tick_q.size(), state);
    end

    // Step outranks run.
    press(1, 0, 1, e);
    wait_to(e);
    tests_run++;
    if (state !== 2'd2) begin tests_failed++; $display("[TB] FAIL step_over_run: got %0d expected 2", state); end
    wait_to(e + 2 * p + 2);
    errs = tick_errors(e + p, p, 2);
    tests_run++;
    if (errs !== 0 || state !== 2'd0) begin tests_failed++; $display("[TB] FAIL step_over_run_ticks: got ticks=%0d state=%0d expected 2/0", tick_q.size(), state); end
    model_cnt = sat_add(model_cnt, 2);
  endtask

  task automatic test_reset_mid_step();
    int entry, p, errs;
    devide = 4'd2; p = 4; step_n = 8'd4; tick_q.delete();
    press(0, 0, 1, entry);
    wait_to(entry + 2 * p + 1);
    errs = tick_errors(entry + p, p, 2);
    tests_run++;
    if (errs !== 0) begin tests_failed++; $display("[TB] FAIL pre_reset_ticks: got %0d ticks expected 2", tick_q.size()); end
    btn_step = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL abort_state: got %0d expected 0", state); end
    tests_run++;
    if (cycle_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL abort_cnt: got %0d expected 0", cycle_cnt); end
    tests_run++;
    if (cpu_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_tick: got %0b expected 0", cpu_tick); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 32'd0;
    tick_q.delete();
    repeat (12) @(negedge clk);
    tests_run++;
    if (tick_q.size() != 0 || state !== 2'd0) begin
      tests_failed++; $display("[TB] FAIL held_step: got ticks=%0d state=%0d expected 0/0", tick_q.size(), state);
    end
    btn_step = 1'b0;
    @(negedge clk);
    press(0, 0, 1, entry);
    wait_to(entry + 4 * p + 3);
    errs = tick_errors(entry + p, p, 4);
    tests_run++;
    if (errs !== 0 || state !== 2'd0) begin tests_failed++; $display("[TB] FAIL repress_step: got ticks=%0d state=%0d expected 4/0", tick_q.size(), state); end
    model_cnt = sat_add(model_cnt, 4);
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL repress_cnt: got %0d expected %0d", cycle_cnt, model_cnt); end
  endtask

  task automatic test_saturate();
    int e, errs;
    devide = 4'd0;
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_cnt;
    #1;
    model_cnt = 32'hFFFF_FFFE;
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL sat_preload: got %0h expected %0h", cycle_cnt, model_cnt); end
    step_n = 8'd2; tick_q.delete();
    press(0, 0, 1, e);
    wait_to(e + 5);
    errs = tick_errors(e + 1, 1, 2);
    model_cnt = sat_add(model_cnt, 2);
    tests_run++;
    if (errs !== 0) begin tests_failed++; $display("[TB] FAIL sat_ticks: got %0d ticks expected 2", tick_q.size()); end
    tests_run++;
    if (cycle_cnt !== model_cnt) begin tests_failed++; $display("[TB] FAIL sat_max: got %0h expected %0h", cycle_cnt, model_cnt); end
    step_n = 8'd3; tick_q.delete();
    press(0, 0, 1, e);
    wait_to(e + 6);
    errs = tick_errors(e + 1, 1, 3);
    model_cnt = sat_add(model_cnt, 3);
    tests_run++;
    if (errs !== 0 || cycle_cnt !== model_cnt) begin
      tests_failed++; $display("[TB] FAIL sat_hold: got ticks=%0d cnt=%0h expected 3/%0h", tick_q.size(), cycle_cnt, model_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_simultaneous();
    test_reset_mid_step();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sm_run_ctrl

// File: doc/sm_run_ctrl.md
SM_RUN_CTRL -- requirements
Module: sm_run_ctrl

Interface
REQ-001 Parameter SHIFT, default 16, base exponent of the CPU tick period.
REQ-002 clk  in  1  system clock, single clock domain.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 devide  in  4  period exponent offset; tick period = 2^min(SHIFT+devide,31) clk cycles.
REQ-005 btnRun  in  1  run request, level, already debounced.
REQ-006 btnHalt  in  1  halt request, level, already debounced.
REQ-007 btnStep  in  1  step request, level, already debounced.
REQ-008 stepN  in  8  CPU ticks per step press; value 0 is treated as 1.
REQ-009 bpEnable  in  1  breakpoint enable.
REQ-010 bpAddr  in  32  breakpoint instruction address.
REQ-011 pc  in  32  current CPU instruction address (imAddr).
REQ-012 cpuTick  out  1  one-clk-wide CPU clock-enable pulse.
REQ-013 state  out  2  HALT=0, RUN=1, STEP=2, BREAK=3.
REQ-014 cycleCnt  out  32  count of issued cpuTick pulses.
REQ-015 bpHit  out  1  high while state==BREAK.

Function
REQ-016 Each button SHALL be rising-edge detected via a registered previous value; an edge is a one-cycle event in the cycle after the 0->1 input change.
REQ-017 Simultaneous edges SHALL be prioritised halt > step > run; lower-priority edges in that cycle are discarded.
REQ-018 Prescaler: 32-bit counter, increments every clk; at terminal (count >= 2^E-1, E=min(SHIFT+devide,31)) it SHALL wrap to 0; a devide change takes effect on the next compare.
REQ-019 Prescaler SHALL be cleared to 0 on every entry into RUN or STEP, so the first tick occurs 2^E cycles after entry.
REQ-020 cpuTick SHALL be 1 exactly in a terminal cycle while state is RUN or STEP, except as blocked by REQ-023.
REQ-021 HALT: run edge -> RUN; step edge -> STEP with stepsLeft = max(stepN,1); halt edge ignored.
REQ-022 RUN: halt edge -> HALT; step edge -> STEP with stepsLeft loaded.
REQ-023 RUN breakpoint: at a terminal cycle with bpEnable=1 and pc==bpAddr, cpuTick SHALL NOT be issued and state -> BREAK, unless the bpSkip flag is set.
REQ-024 bpSkip SHALL be set on a BREAK->RUN transition and cleared at the first terminal cycle in RUN, which issues a tick regardless of pc match.
REQ-025 STEP: each tick decrements stepsLeft; the tick issued with stepsLeft==1 SHALL move state to HALT in the next cycle; halt edge -> HALT immediately, no tick that cycle; breakpoints are ignored in STEP; run/step edges are ignored.
REQ-026 BREAK: run edge -> RUN (bpSkip set); step edge -> STEP; halt edge -> HALT.
REQ-027 cycleCnt SHALL increment by 1 per cpuTick and saturate at 0xFFFF_FFFF.
REQ-028 Outputs SHALL be registered; state change is visible the cycle after the causing event.

Reset
REQ-029 rst_n low SHALL asynchronously force: state=HALT, cpuTick=0, cycleCnt=0, bpHit=0, prescaler=0, stepsLeft=0, bpSkip=0, edge-detect history=0.
REQ-030 Reset asserted mid-RUN or mid-STEP SHALL abort immediately; no tick is issued during or in the first cycle after reset.
REQ-031 Button held high through reset release SHALL NOT produce an edge until released and pressed again (history loads the input on the first clock after release).

Structure
REQ-032 State encodings and the clamp constant 31 SHALL live in the shared sm_config include, used by this block and the CPU debug logic.
REQ-033 One sub-module sm_edge_detect (1-bit, clk/rst_n, rising-edge pulse out) SHALL be instantiated three times.

Verification (SHIFT=0)
REQ-034 devide=2, press btnRun -> state=RUN; cpuTick pulses every 4 clks, first pulse 4 clks after entry; after 10 ticks cycleCnt=10.
REQ-035 HALT, stepN=3, press btnStep -> exactly 3 ticks 4 clks apart, then state=HALT; stepN=0 -> exactly 1 tick.
REQ-036 bpEnable=1, bpAddr=0x20, pc forced 0x20 in RUN -> no tick, state=BREAK, bpHit=1; press btnRun -> first tick issued despite match, then BREAK again at the next terminal.
REQ-037 btnHalt and btnRun rising in the same cycle while RUN -> state=HALT, no further ticks.
REQ-038 rst_n pulsed low mid-STEP with stepsLeft=2 -> state=HALT, cycleCnt=0, cpuTick=0 at once; btnStep held through release -> no step until re-pressed.
REQ-039 cycleCnt preloaded near max via force to 0xFFFF_FFFE, two ticks -> cycleCnt=0xFFFF_FFFF, held.
